switch_poll_master: RTL and testbench

Avalon-MM master that periodically reads the 17-bit switch PIO data register (address 0), debounces the sampled value, and publishes a stable switch vector with a one-cycle change strobe. It is the initiator for the switch input port's s1 slave and sits between that port and user logic, so the Nios II core no longer needs to poll switches.

---
 rtl/pio_pkg.sv | 20 ++
 rtl/switch_debounce.sv | 69 ++++++
 rtl/switch_poll_master.sv | 110 +++++++++++
 tb/tb_switch_poll_master.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pio_pkg.sv
// Shared definitions for the switch PIO poller: register address, FSM encoding, switch width.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pio_pkg;

  // Data register of the switch PIO slave
  localparam logic [1:0] PIO_DATA_ADDR = 2'd0;

  // Width of the switch bank
  localparam int SW_W = 17;

  // Poll transaction sequence
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    CAPT = 2'd2,
    EVAL = 2'd3
  } poll_state_t;

endpackage

// File: rtl/switch_debounce.sv
// Debounces a strobed switch sample: accepts it after STABLE_CNT identical samples in a row.
// Latency: sw_state/sw_changed update on the clock edge that ends the strobe cycle.
// Backpressure: none; every strobed sample is evaluated.
//
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   sample         switch sample to evaluate
//   sample_strobe  one-cycle qualifier for sample
//   sw_state       last accepted switch vector
//   sw_valid       set once the first value is accepted, held until reset
//   sw_changed     one-cycle pulse when sw_state updates
module switch_debounce
  import pio_pkg::*;
#(
  parameter int DATA_W     = SW_W,
  parameter int STABLE_CNT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] sample,
  input  logic              sample_strobe,
  output logic [DATA_W-1:0] sw_state,
  output logic              sw_valid,
  output logic              sw_changed
);

  localparam int              CNT_W   = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT - 1);

  logic [DATA_W-1:0] candidate;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              accept;

  // A differing sample restarts the run; a matching one extends it, saturating
  // so a long-stable input keeps satisfying the acceptance test.
  always_comb begin
    cnt_nxt = cnt;
    if (sample != candidate) begin
      cnt_nxt = '0;
    end else if (cnt != CNT_MAX) begin
      cnt_nxt = cnt + CNT_W'(1);
    end
    // Re-accepting the current value is suppressed so there is no repeat pulse.
    accept = (cnt_nxt == CNT_MAX) && ((sample != sw_state) || !sw_valid);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      candidate  <= '0;
      cnt        <= '0;
      sw_state   <= '0;
      sw_valid   <= 1'b0;
      sw_changed <= 1'b0;
    end else begin
      sw_changed <= 1'b0;
      if (sample_strobe) begin
        candidate <= sample;
        cnt       <= cnt_nxt;
        if (accept) begin
          sw_state   <= sample;
          sw_valid   <= 1'b1;
          sw_changed <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/switch_poll_master.sv
// Avalon-MM master that polls the switch PIO data register and publishes a debounced vector.
// Latency: tick to sw_state/sw_changed is 4 cycles with no waitrequest (REQ, CAPT, EVAL, output).
// Backpressure: avm_read held through avm_waitrequest; ticks arriving while busy are dropped.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   enable              level-sensitive polling enable
//   avm_address         constant data-register address
//   avm_read            read request, high for 1 + waitrequest cycles
//   avm_waitrequest     slave stall
//   avm_readdata        slave data, valid the cycle after acceptance
//   sw_state/sw_valid/sw_changed  debounced outputs
module switch_poll_master
  import pio_pkg::*;
#(
  parameter int DATA_W     = SW_W,
  parameter int POLL_DIV   = 50000,
  parameter int STABLE_CNT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  output logic [1:0]        avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  output logic [DATA_W-1:0] sw_state,
  output logic              sw_valid,
  output logic              sw_changed
);

  localparam int               DIV_W    = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(POLL_DIV - 1);

  logic [DIV_W-1:0]  poll_cnt;
  logic              tick;
  poll_state_t       state;
  poll_state_t       state_nxt;
  logic [DATA_W-1:0] sample;

  assign avm_address = PIO_DATA_ADDR;

  // Free-running divider; parked at 0 while disabled so re-enable gives a full period.
  assign tick = enable && (poll_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      poll_cnt <= '0;
    end else if (!enable || tick) begin
      poll_cnt <= '0;
    end else begin
      poll_cnt <= poll_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Only IDLE looks at tick, so a tick during a transaction is simply lost.
  // REQ ignores enable: an issued read must run to acceptance.
  always_comb begin
    state_nxt = state;
    avm_read  = 1'b0;
    case (state)
      IDLE: if (tick) state_nxt = REQ;
      REQ: begin
        avm_read = 1'b1;
        if (!avm_waitrequest) state_nxt = CAPT;
      end
      CAPT:    state_nxt = EVAL;
      EVAL:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Read data arrives the cycle after acceptance, which is exactly CAPT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sample <= '0;
    end else if (state == CAPT) begin
      sample <= avm_readdata[DATA_W-1:0];
    end
  end

  generate
    if (DATA_W < 32) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^avm_readdata[31:DATA_W];
    end
  endgenerate

  switch_debounce #(
    .DATA_W     (DATA_W),
    .STABLE_CNT (STABLE_CNT)
  ) u_debounce (
    .clk           (clk),
    .reset_n       (reset_n),
    .sample        (sample),
    .sample_strobe (state == EVAL),
    .sw_state      (sw_state),
    .sw_valid      (sw_valid),
    .sw_changed    (sw_changed)
  );

endmodule

// File: tb/tb_switch_poll_master.sv
// Directed bench for switch_poll_master with POLL_DIV=8, STABLE_CNT=3 and a registered PIO model.
// Latency: n/a (testbench).
// Backpressure: bench drives avm_waitrequest per poll.
module tb_switch_poll_master;

  localparam int POLL_DIV   = 8;
  localparam int STABLE_CNT = 3;
  localparam int DW         = 17;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic [1:0]    avm_address;
  logic          avm_read;
  logic          avm_waitrequest = 1'b0;
  logic [31:0]   avm_readdata = '0;
  logic [DW-1:0] sw_state;
  logic          sw_valid;
  logic          sw_changed;

  logic [31:0]   pio_data = '0;
  int            cyc = 0;
  int            n_vec = 0;
  int            n_err = 0;

  // Bounce sequence: samples and the expected outputs after each one is evaluated
  logic [31:0]   bnc_val [8] = '{32'h0, 32'h0, 32'h0, 32'h1, 32'h0, 32'h1, 32'h1, 32'h1};
  logic          bnc_chg [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [31:0]   bnc_st  [8] = '{32'h1A5A5, 32'h1A5A5, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1};

  switch_poll_master #(
    .DATA_W     (DW),
    .POLL_DIV   (POLL_DIV),
    .STABLE_CNT (STABLE_CNT)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .enable          (enable),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_waitrequest (avm_waitrequest),
    .avm_readdata    (avm_readdata),
    .sw_state        (sw_state),
    .sw_valid        (sw_valid),
    .sw_changed      (sw_changed)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // PIO slave: readdata registered on the accepting edge
  always @(posedge clk) begin
    if (avm_read && !avm_waitrequest) avm_readdata <= pio_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
    end
  endtask

  // Serve one read: present v, stall for 'stall' cycles, optionally drop enable
  // in the first REQ cycle. Returns at the cycle the debounced outputs update.
  task automatic do_poll(input logic [31:0] v, input int stall, input bit drop_en,
                         output int r_start, output int rd_len);
    int t;
    pio_data = v;
    avm_waitrequest = (stall > 0);
    t = 0;
    while (!avm_read && t < 40) begin
      @(negedge clk);
      t++;
    end
    r_start = cyc;
    rd_len  = 0;
    if (!avm_read) begin
      check("read_timeout", 32'd0, 32'd1);
      avm_waitrequest = 1'b0;
      return;
    end
    while (avm_read && rd_len < 40) begin
      avm_waitrequest = (rd_len < stall);
      if (drop_en && rd_len == 0) enable = 1'b0;
      @(negedge clk);
      rd_len++;
    end
    avm_waitrequest = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    int e, r0, r1, r2, len, nrd, t;

    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_read",    avm_read,    0);
    check("rst_addr",    avm_address, 0);
    check("rst_state",   sw_state,    0);
    check("rst_valid",   sw_valid,    0);
    check("rst_changed", sw_changed,  0);
    reset_n = 1'b1;
    @(negedge clk);

    // Basic acquire
    enable = 1'b1;
    e = cyc;
    do_poll(32'h1A5A5, 0, 0, r0, len);
    check("acq_first_gap", r0 - e, 8);
    check("acq_chg1", sw_changed, 0);
    check("acq_valid1", sw_valid, 0);
    do_poll(32'h1A5A5, 0, 0, r1, len);
    check("acq_gap2", r1 - r0, 8);
    check("acq_chg2", sw_changed, 0);
    do_poll(32'h1A5A5, 0, 0, r2, len);
    check("acq_gap3", r2 - r1, 8);
    check("acq_rdlen", len, 1);
    check("acq_chg3", sw_changed, 1);
    check("acq_state", sw_state, 32'h1A5A5);
    check("acq_valid3", sw_valid, 1);
    check("acq_addr", avm_address, 0);
    @(negedge clk);
    check("acq_pulse_end", sw_changed, 0);

    // Settle on 0, then bounce before settling on 1
    for (int i = 0; i < 8; i++) begin
      do_poll(bnc_val[i], 0, 0, r0, len);
      check($sformatf("bnc_chg%0d", i), sw_changed, bnc_chg[i]);
      check($sformatf("bnc_st%0d", i), sw_state, bnc_st[i]);
    end

    // Upper readdata bits ignored
    do_poll(32'hFFFE0003, 0, 0, r0, len);
    do_poll(32'hFFFE0003, 0, 0, r0, len);
    check("hi_st2", sw_state, 32'h1);
    do_poll(32'hFFFE0003, 0, 0, r0, len);
    check("hi_chg3", sw_changed, 1);
    check("hi_st3", sw_state, 32'h3);

    // Waitrequest stall: 5 stall cycles, next tick lands in EVAL and is dropped
    do_poll(32'h7, 5, 0, r0, len);
    check("stall_rdlen", len, 6);
    check("stall_chg1", sw_changed, 0);
    do_poll(32'h7, 0, 0, r1, len);
    check("stall_next_gap", r1 - r0, 16);
    do_poll(32'h7, 0, 0, r2, len);
    check("stall_chg3", sw_changed, 1);
    check("stall_st3", sw_state, 32'h7);

    // Disable inside REQ with 2 stall cycles: read completes and is evaluated
    do_poll(32'h9, 0, 0, r0, len);
    do_poll(32'h9, 0, 0, r0, len);
    do_poll(32'h9, 2, 1, r0, len);
    check("dis_rdlen", len, 3);
    check("dis_chg", sw_changed, 1);
    check("dis_st", sw_state, 32'h9);
    nrd = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (avm_read) nrd++;
    end
    check("dis_no_read", nrd, 0);
    enable = 1'b1;
    e = cyc;
    do_poll(32'h9, 0, 0, r0, len);
    check("reen_gap", r0 - e, 8);
    check("reen_chg", sw_changed, 0);

    // Reset during CAPT
    pio_data = 32'h15;
    t = 0;
    while (!avm_read && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("rstx_read_seen", avm_read, 1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("rstx_read",    avm_read,   0);
    check("rstx_state",   sw_state,   0);
    check("rstx_valid",   sw_valid,   0);
    check("rstx_changed", sw_changed, 0);
    @(negedge clk);
    reset_n = 1'b1;
    e = cyc;
    do_poll(32'h15, 0, 0, r0, len);
    check("rstx_gap", r0 - e, 8);
    check("rstx_valid1", sw_valid, 0);
    do_poll(32'h15, 0, 0, r0, len);
    check("rstx_valid2", sw_valid, 0);
    check("rstx_chg2", sw_changed, 0);
    do_poll(32'h15, 0, 0, r0, len);
    check("rstx_chg3", sw_changed, 1);
    check("rstx_st3", sw_state, 32'h15);
    check("rstx_valid3", sw_valid, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
